// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction-memory loader slice.
//   state_t     : loader FSM state encoding
//   WORD_BYTES  : bytes per instruction word
//   BIG_ENDIAN  : byte order of the incoming stream (first byte lands in [31:24])
// ----------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int WORD_W     = WORD_BYTES * 8;

  // The first byte of each word on the stream is the most significant one.
  localparam bit BIG_ENDIAN = 1'b1;

endpackage

// File: rtl/imem_loader_if.sv
// ----------------------------------------------------------------------------
// imem_loader_if
// Groups the byte-stream handshake, the instruction-memory write port and the
// load status lines of the loader.
//   start        : one-cycle pulse that begins a load
//   in_byte      : stream data byte
//   in_valid     : in_byte is valid this cycle
//   in_ready     : loader accepts in_byte this cycle
//   out_we       : instruction-memory write strobe (one cycle per word)
//   out_addr     : word-aligned byte address of the write
//   out_wdata    : instruction word to write
//   out_cpu_hold : stalls the PC/fetch while high
//   out_done     : image loaded, sticky until the next start
//   out_error    : length exceeded memory depth, sticky until the next start
//
// Handshake: a byte moves on a rising clk edge where in_valid && in_ready.
// The source holds in_byte stable while in_valid is high and in_ready is low;
// in_ready depends only on loader state, never on in_valid.
//
// Modports: master = loader side, slave = stream source / memory / CPU side.
// ----------------------------------------------------------------------------
interface imem_loader_if;

  logic        start;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        out_we;
  logic [31:0] out_addr;
  logic [31:0] out_wdata;
  logic        out_cpu_hold;
  logic        out_done;
  logic        out_error;

  modport master (
    input  start, in_byte, in_valid,
    output in_ready, out_we, out_addr, out_wdata,
    output out_cpu_hold, out_done, out_error
  );

  modport slave (
    output start, in_byte, in_valid,
    input  in_ready, out_we, out_addr, out_wdata,
    input  out_cpu_hold, out_done, out_error
  );

endinterface

// File: rtl/imem_word_packer.sv
// ----------------------------------------------------------------------------
// imem_word_packer
// Assembles stream bytes into instruction words.
//   clk, rst_n  : clock / asynchronous active-low reset
//   clr         : clears the shift register and byte counter (new load)
//   take        : a data byte is transferred this cycle
//   byte_in     : the transferred byte
//   word_ready  : this transfer completes a word (combinational, for the FSM)
//   word        : shift-register contents (registered)
// ----------------------------------------------------------------------------
module imem_word_packer
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              take,
  input  logic [7:0]        byte_in,
  output logic              word_ready,
  output logic [WORD_W-1:0] word
);

  localparam int              CNT_W = $clog2(WORD_BYTES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORD_BYTES - 1);

  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clr) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (take) begin
      // Counter wraps naturally back to 0 after the last byte of a word.
      cnt_q <= cnt_q + 1'b1;
      if (BIG_ENDIAN) begin
        word_q <= {word_q[WORD_W-9:0], byte_in};
      end else begin
        word_q <= {byte_in, word_q[WORD_W-1:8]};
      end
    end
  end

  assign word_ready = take && (cnt_q == LAST);
  assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
// Writer side of the instruction-memory interface. Receives a 2-byte
// big-endian length header (in words) followed by the program image, writes
// each assembled word to consecutive word-aligned addresses from 0, and keeps
// the CPU held until the image is complete.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : imem_loader_if.master (stream, write port, status)
//   dbg_state : current FSM state
// All bus outputs are flops or decodes of the state register.
// ----------------------------------------------------------------------------
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  imem_loader_if.master bus,
  output state_t dbg_state
);

  localparam int               CMP_W     = LEN_W + 1;
  localparam logic [CMP_W-1:0] MEM_WORDS = CMP_W'(2 ** ADDR_W);

  state_t state_q, state_d;

  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_full;
  logic [ADDR_W:0]   word_cnt_q;
  logic [ADDR_W:0]   word_cnt_next;
  logic [ADDR_W-1:0] addr_q;
  logic              last_word;

  logic xfer;
  logic start_ok;
  logic len_hi_ld;
  logic len_lo_ld;
  logic wr_step;

  logic              word_ready;
  logic [WORD_W-1:0] word;

  // --------------------------------------------------------------------------
  // State decodes driving the bus
  // --------------------------------------------------------------------------
  assign bus.in_ready     = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                            (state_q == DATA);
  assign bus.out_we       = (state_q == WRITE);
  assign bus.out_done     = (state_q == DONE);
  assign bus.out_error    = (state_q == ERR);
  assign bus.out_cpu_hold = (state_q != DONE);
  assign bus.out_addr     = 32'({addr_q, 2'b00});
  assign bus.out_wdata    = word;
  assign dbg_state        = state_q;

  assign xfer = bus.in_valid && bus.in_ready;

  // Full length as seen while the low header byte is on the bus.
  assign len_full      = {len_q[LEN_W-1 -: 8], bus.in_byte};
  assign word_cnt_next = word_cnt_q + 1'b1;
  assign last_word     = (LEN_W'(word_cnt_next) == len_q);

  // --------------------------------------------------------------------------
  // Byte-to-word assembly
  // --------------------------------------------------------------------------
  imem_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_ok),
    .take       (xfer && (state_q == DATA)),
    .byte_in    (bus.in_byte),
    .word_ready (word_ready),
    .word       (word)
  );

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    len_hi_ld = 1'b0;
    len_lo_ld = 1'b0;
    wr_step   = 1'b0;
    case (state_q)
      // in_ready is low in these states, so a byte offered alongside start
      // is never consumed.
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          start_ok = 1'b1;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          len_hi_ld = 1'b1;
          state_d   = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_lo_ld = 1'b1;
          if (len_full == '0) begin
            state_d = DONE;
          end else if ({1'b0, len_full} > MEM_WORDS) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (word_ready) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        wr_step = 1'b1;
        state_d = last_word ? DONE : DATA;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, length and address/word counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        word_cnt_q <= '0;
        addr_q     <= '0;
      end
      if (len_hi_ld) begin
        len_q[LEN_W-1 -: 8] <= bus.in_byte;
      end
      if (len_lo_ld) begin
        len_q[7:0] <= bus.in_byte;
      end
      if (wr_step) begin
        word_cnt_q <= word_cnt_next;
        // The address stays on the final word so it never leaves the memory
        // range, even for a full 2**ADDR_W-word image.
        if (!last_word) begin
          addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

endmodule
